// File: rtl/game_pkg.sv
// Shared state encoding and width helpers for the maze-game flow controller.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
package game_pkg;

  typedef enum logic [2:0] {
    START    = 3'd0,
    PLAY     = 3'd1,
    DYING    = 3'd2,
    LEVEL_UP = 3'd3,
    OVER     = 3'd4,
    WIN      = 3'd5,
    PAUSED   = 3'd6
  } game_state_t;

  function automatic int lives_w(input int lives);
    return (lives < 1) ? 1 : $clog2(lives + 1);
  endfunction

  function automatic int level_w(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

  function automatic int timer_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Event inputs and layer/control outputs of the game flow controller.
// master = controller side, slave = video/sprite side.
interface game_flow_ctrl_if #(
  parameter int NUM_GHOSTS = 2,
  parameter int LW         = 2,
  parameter int VW         = 2
);
  logic                  frame_tick;
  logic                  begingame;
  logic                  died;
  logic                  level_clear;
  logic                  pause_btn;
  logic                  start;
  logic                  drawwall;
  logic                  drawpacman;
  logic [NUM_GHOSTS-1:0] drawghost;
  logic                  drawdot;
  logic                  endgame;
  logic                  win;
  logic                  freeze;
  logic                  respawn;
  logic                  dot_reload;
  logic [LW-1:0]         lives_left;
  logic [VW-1:0]         level;

  modport master (
    input  frame_tick, begingame, died, level_clear, pause_btn,
    output start, drawwall, drawpacman, drawghost, drawdot,
    output endgame, win, freeze, respawn, dot_reload,
    output lives_left, level
  );

  modport slave (
    output frame_tick, begingame, died, level_clear, pause_btn,
    input  start, drawwall, drawpacman, drawghost, drawdot,
    input  endgame, win, freeze, respawn, dot_reload,
    input  lives_left, level
  );
endinterface

// File: rtl/frame_hold_timer.sv
// Counts frame ticks after a clear; done fires on the tick that
// reaches limit. Holds at limit-1 so it never wraps.
module frame_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         frame_tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  assign done = frame_tick && (cnt == limit - W'(1));

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (frame_tick && !done)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title, play, death/level interludes, game over, win.
// Build with GAME_PAUSE_EN to add the PAUSED state driven by pause_btn.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_GHOSTS   = 2,
  parameter int LIVES        = 3,
  parameter int LEVELS       = 4,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_FRAMES = 90
) (
  input  logic             clk,
  input  logic             reset,
  game_flow_ctrl_if.master g
);

  localparam int LW = lives_w(LIVES);
  localparam int VW = level_w(LEVELS);
  localparam int TW = timer_w(DEATH_FRAMES, LEVEL_FRAMES);

  game_state_t state, state_n;

  logic [LW-1:0] lives_q;
  logic [VW-1:0] level_q;
  logic          resp_q, reload_q;

  logic dec_life, inc_level, restart;
  logic pulse_resp, pulse_reload;

  logic          interlude;
  logic          t_clear, t_done;
  logic [TW-1:0] t_limit;
  logic          pause_rise;

`ifdef GAME_PAUSE_EN
  logic pb_q, pb_qq;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pb_q  <= 1'b0;
      pb_qq <= 1'b0;
    end else begin
      pb_q  <= g.pause_btn;
      pb_qq <= pb_q;
    end
  end

  assign pause_rise = pb_q && !pb_qq;
`else
  logic unused_pause;
  assign unused_pause = g.pause_btn;
  assign pause_rise   = 1'b0;
`endif

  assign interlude = (state == DYING) || (state == LEVEL_UP);
  assign t_clear   = !reset || (state_n != state);
  assign t_limit   = (state == DYING) ? TW'(DEATH_FRAMES)
                                      : TW'(LEVEL_FRAMES);

  frame_hold_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .clear      (t_clear),
    .frame_tick (g.frame_tick && interlude),
    .limit      (t_limit),
    .done       (t_done)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      state <= START;
    else
      state <= state_n;
  end

  always_comb begin
    state_n      = state;
    dec_life     = 1'b0;
    inc_level    = 1'b0;
    restart      = 1'b0;
    pulse_resp   = 1'b0;
    pulse_reload = 1'b0;
    unique case (state)
      START: begin
        if (g.begingame) begin
          state_n      = PLAY;
          pulse_resp   = 1'b1;
          pulse_reload = 1'b1;
        end
      end
      PLAY: begin
        if (g.died) begin
          dec_life = 1'b1;
          state_n  = (lives_q <= LW'(1)) ? OVER : DYING;
        end else if (g.level_clear) begin
          state_n = (level_q == VW'(LEVELS - 1)) ? WIN : LEVEL_UP;
        end else if (pause_rise) begin
          state_n = PAUSED;
        end
      end
      DYING: begin
        if (t_done) begin
          state_n    = PLAY;
          pulse_resp = 1'b1;
        end
      end
      LEVEL_UP: begin
        if (t_done) begin
          state_n      = PLAY;
          inc_level    = 1'b1;
          pulse_resp   = 1'b1;
          pulse_reload = 1'b1;
        end
      end
      OVER, WIN: begin
        if (g.begingame) begin
          state_n = START;
          restart = 1'b1;
        end
      end
      PAUSED: begin
        if (pause_rise)
          state_n = PLAY;
      end
      default: state_n = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      lives_q <= LW'(LIVES);
      level_q <= '0;
    end else begin
      if (dec_life && lives_q != '0)
        lives_q <= lives_q - LW'(1);
      if (inc_level && level_q != VW'(LEVELS - 1))
        level_q <= level_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_q   <= 1'b0;
      reload_q <= 1'b0;
    end else begin
      resp_q   <= pulse_resp;
      reload_q <= pulse_reload;
    end
  end

  always_comb begin
    g.start      = 1'b0;
    g.drawwall   = 1'b0;
    g.drawpacman = 1'b0;
    g.drawghost  = '0;
    g.drawdot    = 1'b0;
    g.endgame    = 1'b0;
    g.win        = 1'b0;
    g.freeze     = 1'b1;
    unique case (state)
      START: g.start = 1'b1;
      PLAY, PAUSED: begin
        g.drawwall   = 1'b1;
        g.drawpacman = 1'b1;
        g.drawghost  = '1;
        g.drawdot    = 1'b1;
        g.freeze     = (state == PAUSED);
      end
      DYING: begin
        g.drawwall = 1'b1;
        g.drawdot  = 1'b1;
      end
      LEVEL_UP: g.drawwall = 1'b1;
      OVER:     g.endgame  = 1'b1;
      WIN:      g.win      = 1'b1;
      default:  g.start    = 1'b1;
    endcase
  end

  assign g.respawn    = resp_q;
  assign g.dot_reload = reload_q;
  assign g.lives_left = lives_q;
  assign g.level      = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl (LIVES=3, LEVELS=2, 2 ghosts).
// Pause steps run only when GAME_PAUSE_EN is defined.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.NUM_GHOSTS(2), .LW(2), .VW(1)) gi ();

  game_flow_ctrl #(
    .NUM_GHOSTS   (2),
    .LIVES        (3),
    .LEVELS       (2),
    .DEATH_FRAMES (60),
    .LEVEL_FRAMES (90)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .g     (gi.master)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      gi.frame_tick = 1'b1;
      step();
      gi.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b0;
    gi.frame_tick  = 1'b0;
    gi.begingame   = 1'b0;
    gi.died        = 1'b0;
    gi.level_clear = 1'b0;
    gi.pause_btn   = 1'b0;

    // T1: reset and start
    step();
    step();
    chk("rst_start", {31'd0, gi.start}, 1);
    chk("rst_freeze", {31'd0, gi.freeze}, 1);
    chk("rst_draws", {27'd0, gi.drawwall, gi.drawpacman,
        gi.drawghost, gi.drawdot}, 0);
    chk("rst_lives", {30'd0, gi.lives_left}, 3);
    chk("rst_pulses", {30'd0, gi.respawn, gi.dot_reload}, 0);
    reset        = 1'b1;
    gi.begingame = 1'b1;
    step();
    gi.begingame = 1'b0;
    chk("t1_play", {26'd0, gi.start, gi.drawwall, gi.drawpacman,
        gi.drawghost, gi.drawdot}, 6'b011111);
    chk("t1_pulses", {30'd0, gi.respawn, gi.dot_reload}, 3);
    chk("t1_freeze", {31'd0, gi.freeze}, 0);
    chk("t1_lives", {30'd0, gi.lives_left}, 3);
    step();
    chk("t1_pulse_end", {30'd0, gi.respawn, gi.dot_reload}, 0);

    // T2: death interlude timing
    gi.died = 1'b1;
    step();
    gi.died = 1'b0;
    chk("t2_dying", {27'd0, gi.drawwall, gi.drawpacman,
        gi.drawghost, gi.drawdot}, 5'b10001);
    chk("t2_freeze", {31'd0, gi.freeze}, 1);
    chk("t2_lives", {30'd0, gi.lives_left}, 2);
    ticks(59);
    chk("t2_59", {30'd0, gi.drawpacman, gi.drawwall}, 1);
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("t2_back", {30'd0, gi.drawpacman, gi.freeze}, 2);
    chk("t2_resp", {30'd0, gi.respawn, gi.dot_reload}, 2);
    step();
    chk("t2_resp_end", {31'd0, gi.respawn}, 0);

    // T3: run out of lives, restart
    gi.died = 1'b1;
    step();
    gi.died = 1'b0;
    chk("t3_lives1", {30'd0, gi.lives_left}, 1);
    ticks(60);
    chk("t3_play", {31'd0, gi.drawpacman}, 1);
    gi.died = 1'b1;
    step();
    chk("t3_over", {30'd0, gi.endgame, gi.freeze}, 3);
    chk("t3_lives0", {30'd0, gi.lives_left}, 0);
    step();
    gi.died = 1'b0;
    chk("t3_sat", {30'd0, gi.lives_left}, 0);
    gi.begingame = 1'b1;
    step();
    chk("t3_start", {30'd0, gi.start, gi.endgame}, 2);
    chk("t3_relives", {30'd0, gi.lives_left}, 3);
    step();
    gi.begingame = 1'b0;
    chk("t3_replay", {31'd0, gi.drawpacman}, 1);

    // T4: level up then win
    gi.level_clear = 1'b1;
    step();
    gi.level_clear = 1'b0;
    chk("t4_lvlup", {27'd0, gi.drawwall, gi.drawpacman,
        gi.drawghost, gi.drawdot}, 5'b10000);
    ticks(89);
    chk("t4_89", {30'd0, gi.drawwall, gi.drawdot}, 2);
    chk("t4_lvl0", {31'd0, gi.level}, 0);
    gi.frame_tick = 1'b1;
    step();
    gi.frame_tick = 1'b0;
    chk("t4_lvl1", {31'd0, gi.level}, 1);
    chk("t4_pulses", {30'd0, gi.respawn, gi.dot_reload}, 3);
    chk("t4_play", {31'd0, gi.drawdot}, 1);
    gi.level_clear = 1'b1;
    step();
    gi.level_clear = 1'b0;
    chk("t4_win", {30'd0, gi.win, gi.freeze}, 3);
    chk("t4_lvl_hold", {31'd0, gi.level}, 1);
    gi.begingame = 1'b1;
    step();
    chk("t4_restart", {29'd0, gi.start, gi.level, gi.win}, 3'b100);
    step();
    gi.begingame = 1'b0;

    // T5: died beats level_clear; reset aborts interlude
    gi.died        = 1'b1;
    gi.level_clear = 1'b1;
    step();
    gi.died        = 1'b0;
    gi.level_clear = 1'b0;
    chk("t5_dying", {30'd0, gi.drawdot, gi.drawpacman}, 2);
    chk("t5_level", {31'd0, gi.level}, 0);
    chk("t5_lives", {30'd0, gi.lives_left}, 2);
    ticks(10);
    reset = 1'b0;
    step();
    chk("t5_start", {31'd0, gi.start}, 1);
    chk("t5_nopulse", {30'd0, gi.respawn, gi.dot_reload}, 0);
    reset = 1'b1;
    step();
    chk("t5_nopulse2", {30'd0, gi.respawn, gi.dot_reload}, 0);
    chk("t5_relives", {30'd0, gi.lives_left}, 3);

`ifdef GAME_PAUSE_EN
    // T6: pause toggle
    gi.begingame = 1'b1;
    step();
    gi.begingame = 1'b0;
    gi.pause_btn = 1'b1;
    step();
    step();
    step();
    chk("t6_paused", {30'd0, gi.freeze, gi.drawpacman}, 3);
    gi.died = 1'b1;
    step();
    gi.died = 1'b0;
    chk("t6_ignore", {30'd0, gi.lives_left}, 3);
    gi.pause_btn = 1'b0;
    step();
    step();
    gi.pause_btn = 1'b1;
    step();
    step();
    step();
    gi.pause_btn = 1'b0;
    chk("t6_resume", {30'd0, gi.freeze, gi.drawpacman}, 1);
    chk("t6_lives", {30'd0, gi.lives_left}, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
